safe_entry_controller: RTL and testbench

Sequencing FSM for the safe's code-entry path. It accepts single-cycle keypad digit strobes and assembles them into an entry register. It drives the increment/restart pulses of the digit counter, compares the completed entry against the stored code, and issues unlock, error and attempt-lockout indications to the lock driver and display.

---
 rtl/safe_pkg.sv | 26 ++
 rtl/safe_entry_controller_if.sv | 33 +++
 rtl/safe_hold_timer.sv | 45 ++++
 rtl/safe_entry_controller.sv | 143 ++++++++++++++
 tb/tb_safe_entry_controller.sv | 210 +++++++++++++++++++++
 5 files changed

// File: rtl/safe_pkg.sv
// Shared definitions for the safe code-entry path: state encoding,
// default digit geometry and a helper for picking digits out of a code word.
package safe_pkg;

  localparam int DIGIT_W  = 4;
  localparam int CODE_LEN = 4;

  // Encoding is visible on the debug/display state port, so it is fixed here.
  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_ENTRY   = 3'd1,
    ST_CHECK   = 3'd2,
    ST_OPEN    = 3'd3,
    ST_FAIL    = 3'd4,
    ST_LOCKOUT = 3'd5
  } state_e;

  // Digit 0 lives in the LSBs and is the first digit keyed.
  function automatic logic [DIGIT_W-1:0] code_slot(
    input logic [DIGIT_W*CODE_LEN-1:0] code,
    input int unsigned                 idx
  );
    return code[idx*DIGIT_W +: DIGIT_W];
  endfunction

endpackage

// File: rtl/safe_entry_controller_if.sv
// Keypad, stored-code and lock-driver/display signals of the code-entry
// controller. master drives the keypad side, slave is the controller.
interface safe_entry_controller_if #(
  parameter int DIGIT_W  = safe_pkg::DIGIT_W,
  parameter int CODE_LEN = safe_pkg::CODE_LEN
);

  logic                         key_valid;
  logic [DIGIT_W-1:0]           key_value;
  logic                         enter_pulse;
  logic                         clear_pulse;
  logic [DIGIT_W*CODE_LEN-1:0]  code_word;
  logic                         increment_counter_pulse;
  logic                         restart_pulse;
  logic                         unlock;
  logic                         error;
  logic                         locked_out;
  logic [1:0]                   attempts;
  logic [2:0]                   state;

  modport master (
    output key_valid, key_value, enter_pulse, clear_pulse, code_word,
    input  increment_counter_pulse, restart_pulse, unlock, error,
           locked_out, attempts, state
  );

  modport slave (
    input  key_valid, key_value, enter_pulse, clear_pulse, code_word,
    output increment_counter_pulse, restart_pulse, unlock, error,
           locked_out, attempts, state
  );

endinterface

// File: rtl/safe_hold_timer.sv
// Loadable down-counter shared by the OPEN and LOCKOUT hold periods.
// After a load of N-1, done is high in the N-th cycle following the load.
module safe_hold_timer #(
  parameter int TIMER_W = 9
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               load,
  input  logic [TIMER_W-1:0] load_value,
  output logic               done
);

  logic [TIMER_W-1:0] count_q, count_d;
  logic               active_q, active_d;

  // Load wins; otherwise count down while active and stop once zero is reached.
  always_comb begin
    count_d  = count_q;
    active_d = active_q;
    if (load) begin
      count_d  = load_value;
      active_d = 1'b1;
    end else if (active_q) begin
      if (count_q == '0) begin
        active_d = 1'b0;
      end else begin
        count_d = count_q - TIMER_W'(1);
      end
    end
  end

  // Timer state registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count_q  <= '0;
      active_q <= 1'b0;
    end else begin
      count_q  <= count_d;
      active_q <= active_d;
    end
  end

  assign done = active_q && (count_q == '0);

endmodule

// File: rtl/safe_entry_controller.sv
// Code-entry sequencer: assembles keypad digits, drives the external digit
// counter, checks the entry against the stored code and manages unlock,
// error reporting and attempt lockout. Every output comes straight from a flop.
module safe_entry_controller
  import safe_pkg::*;
#(
  parameter int DIGIT_W        = safe_pkg::DIGIT_W,
  parameter int CODE_LEN       = safe_pkg::CODE_LEN,
  parameter int MAX_ATTEMPTS   = 3,
  parameter int OPEN_CYCLES    = 50,
  parameter int LOCKOUT_CYCLES = 200
) (
  input  logic                    clk,
  input  logic                    sys_reset,
  safe_entry_controller_if.slave  bus
);

  localparam int HOLD_MAX = (OPEN_CYCLES > LOCKOUT_CYCLES) ? OPEN_CYCLES : LOCKOUT_CYCLES;
  localparam int TIMER_W  = $clog2(HOLD_MAX) + 1;
  localparam int IDX_W    = $clog2(CODE_LEN + 1);
  localparam int ENTRY_W  = DIGIT_W * CODE_LEN;
  localparam logic [IDX_W-1:0] FULL_IDX = IDX_W'(CODE_LEN);
  localparam logic [1:0]       MAX_ATT  = 2'(MAX_ATTEMPTS);

  state_e             state_q, state_d;
  logic [IDX_W-1:0]   wr_idx_q, wr_idx_d;
  logic [ENTRY_W-1:0] entry_q, entry_d;
  logic [1:0]         attempts_q, attempts_d;
  logic               inc_q, inc_d;
  logic               restart_q, restart_d;
  logic               unlock_q, unlock_d;
  logic               error_q, error_d;
  logic               locked_q, locked_d;

  logic               accept_key;
  logic               do_clear;
  logic               leaving_open;
  logic               timer_load;
  logic [TIMER_W-1:0] timer_value;
  logic               timer_done;

  safe_hold_timer #(.TIMER_W(TIMER_W)) u_hold_timer (
    .clk        (clk),
    .rst        (sys_reset),
    .load       (timer_load),
    .load_value (timer_value),
    .done       (timer_done)
  );

  // All state, datapath and output flops; reset never emits a restart pulse.
  always_ff @(posedge clk or posedge sys_reset) begin
    if (sys_reset) begin
      state_q    <= ST_IDLE;
      wr_idx_q   <= '0;
      entry_q    <= '0;
      attempts_q <= '0;
      inc_q      <= 1'b0;
      restart_q  <= 1'b0;
      unlock_q   <= 1'b0;
      error_q    <= 1'b0;
      locked_q   <= 1'b0;
    end else begin
      state_q    <= state_d;
      wr_idx_q   <= wr_idx_d;
      entry_q    <= entry_d;
      attempts_q <= attempts_d;
      inc_q      <= inc_d;
      restart_q  <= restart_d;
      unlock_q   <= unlock_d;
      error_q    <= error_d;
      locked_q   <= locked_d;
    end
  end

  // Next-state decision; in IDLE/ENTRY clear beats enter beats key.
  always_comb begin
    state_d    = state_q;
    accept_key = 1'b0;
    do_clear   = 1'b0;
    unique case (state_q)
      ST_IDLE, ST_ENTRY: begin
        if (bus.clear_pulse) begin
          do_clear = 1'b1;
          state_d  = ST_IDLE;
        end else if (bus.enter_pulse && (state_q == ST_ENTRY)) begin
          state_d = (wr_idx_q == FULL_IDX) ? ST_CHECK : ST_FAIL;
        end else if (bus.key_valid && (wr_idx_q < FULL_IDX)) begin
          accept_key = 1'b1;
          state_d    = ST_ENTRY;
        end
      end
      ST_CHECK:   state_d = (entry_q == bus.code_word) ? ST_OPEN : ST_FAIL;
      ST_OPEN:    if (timer_done) state_d = ST_IDLE;
      ST_FAIL:    state_d = (attempts_q >= MAX_ATT) ? ST_LOCKOUT : ST_IDLE;
      ST_LOCKOUT: if (timer_done) state_d = ST_IDLE;
      default:    state_d = ST_IDLE;
    endcase
  end

  // Entry register, write index and attempt counter updates.
  always_comb begin
    wr_idx_d     = wr_idx_q;
    entry_d      = entry_q;
    attempts_d   = attempts_q;
    leaving_open = (state_q == ST_OPEN) && (state_d == ST_IDLE);
    if (accept_key) begin
      entry_d[int'(wr_idx_q)*DIGIT_W +: DIGIT_W] = bus.key_value;
      wr_idx_d = wr_idx_q + IDX_W'(1);
    end
    if (do_clear || leaving_open || (state_d == ST_FAIL)) begin
      wr_idx_d = '0;
      entry_d  = '0;
    end
    if ((state_d == ST_FAIL) && (attempts_q < MAX_ATT)) begin
      attempts_d = attempts_q + 2'd1;
    end
    if ((state_d == ST_OPEN) || ((state_q == ST_LOCKOUT) && (state_d == ST_IDLE))) begin
      attempts_d = '0;
    end
  end

  // Output pulses/flags and hold-timer loading, derived from the next state.
  always_comb begin
    inc_d       = accept_key;
    restart_d   = do_clear || leaving_open || (state_d == ST_FAIL);
    unlock_d    = (state_d == ST_OPEN);
    error_d     = (state_d == ST_FAIL);
    locked_d    = (state_d == ST_LOCKOUT);
    timer_load  = ((state_d == ST_OPEN) && (state_q != ST_OPEN)) ||
                  ((state_d == ST_LOCKOUT) && (state_q != ST_LOCKOUT));
    timer_value = (state_d == ST_OPEN) ? TIMER_W'(OPEN_CYCLES - 1)
                                       : TIMER_W'(LOCKOUT_CYCLES - 1);
  end

  assign bus.increment_counter_pulse = inc_q;
  assign bus.restart_pulse           = restart_q;
  assign bus.unlock                  = unlock_q;
  assign bus.error                   = error_q;
  assign bus.locked_out              = locked_q;
  assign bus.attempts                = attempts_q;
  assign bus.state                   = state_q;

endmodule

// File: tb/tb_safe_entry_controller.sv
// Testbench for safe_entry_controller: table-driven cycle vectors plus
// hand-built sequences for OPEN/LOCKOUT hold lengths and asynchronous reset.
module tb_safe_entry_controller;
  import safe_pkg::*;

  typedef struct {
    string      tag;
    logic       kv;
    logic [3:0] kval;
    logic       ent;
    logic       clr;
    logic       e_inc;
    logic       e_rst;
    logic       e_err;
    logic       e_unl;
    logic       e_lck;
    logic [1:0] e_att;
    logic [2:0] e_st;
  } vec_t;

  localparam logic [15:0] CODE = 16'h4321;

  logic clk = 1'b0;
  logic sys_reset;
  int   compared   = 0;
  int   mismatched = 0;
  vec_t expQ[$];
  vec_t tableV[19];

  always #5 clk = ~clk;

  safe_entry_controller_if #(.DIGIT_W(4), .CODE_LEN(4)) bus ();

  safe_entry_controller #(
    .DIGIT_W(4), .CODE_LEN(4), .MAX_ATTEMPTS(3),
    .OPEN_CYCLES(50), .LOCKOUT_CYCLES(200)
  ) dut (
    .clk       (clk),
    .sys_reset (sys_reset),
    .bus       (bus)
  );

  function automatic vec_t mk(string tag, logic kv, logic [3:0] kval, logic ent, logic clr,
                              logic inc, logic rst, logic err, logic unl, logic lck,
                              logic [1:0] att, logic [2:0] st);
    vec_t v;
    v.tag = tag; v.kv = kv; v.kval = kval; v.ent = ent; v.clr = clr;
    v.e_inc = inc; v.e_rst = rst; v.e_err = err; v.e_unl = unl; v.e_lck = lck;
    v.e_att = att; v.e_st = st;
    return v;
  endfunction

  task automatic checkValue(string name, int got, int exp);
    compared++;
    if (got !== exp) begin
      mismatched++;
      $display("[TB] FAIL %s: got %0d, expected %0d", name, got, exp);
    end
  endtask

  // Pops the oldest expectation and compares it to the current outputs.
  task automatic checkOutput();
    vec_t e;
    compared++;
    if (expQ.size() == 0) begin
      mismatched++;
      $display("[TB] FAIL scoreboard: no expectation queued");
      return;
    end
    e = expQ.pop_front();
    if ({bus.increment_counter_pulse, bus.restart_pulse, bus.error, bus.unlock,
         bus.locked_out, bus.attempts, bus.state} !==
        {e.e_inc, e.e_rst, e.e_err, e.e_unl, e.e_lck, e.e_att, e.e_st}) begin
      mismatched++;
      $display("[TB] FAIL %s: got inc=%0b rst=%0b err=%0b unl=%0b lck=%0b att=%0d st=%0d, expected inc=%0b rst=%0b err=%0b unl=%0b lck=%0b att=%0d st=%0d",
               e.tag, bus.increment_counter_pulse, bus.restart_pulse, bus.error, bus.unlock,
               bus.locked_out, bus.attempts, bus.state,
               e.e_inc, e.e_rst, e.e_err, e.e_unl, e.e_lck, e.e_att, e.e_st);
    end
  endtask

  // Called at a falling edge: drive one cycle of inputs, queue the outputs
  // expected after the next rising edge, and check them at the next falling edge.
  task automatic applyStimulus(input vec_t v);
    bus.key_valid   = v.kv;
    bus.key_value   = v.kval;
    bus.enter_pulse = v.ent;
    bus.clear_pulse = v.clr;
    expQ.push_back(v);
    @(negedge clk);
    bus.key_valid   = 1'b0;
    bus.key_value   = '0;
    bus.enter_pulse = 1'b0;
    bus.clear_pulse = 1'b0;
    checkOutput();
  endtask

  task automatic enterWrong(input logic [1:0] prevAtt);
    for (int i = 0; i < 4; i++)
      applyStimulus(mk("wrong key", 1, 4'd1, 0, 0, 1, 0, 0, 0, 0, prevAtt, 3'd1));
    applyStimulus(mk("wrong enter", 0, 0, 1, 0, 0, 0, 0, 0, 0, prevAtt, 3'd2));
    applyStimulus(mk("wrong reject", 0, 0, 0, 0, 0, 1, 1, 0, 0, prevAtt + 2'd1, 3'd4));
  endtask

  task automatic enterCorrect(input logic [1:0] prevAtt);
    for (int i = 0; i < 4; i++)
      applyStimulus(mk("good key", 1, code_slot(CODE, i), 0, 0, 1, 0, 0, 0, 0, prevAtt, 3'd1));
    applyStimulus(mk("good enter", 0, 0, 1, 0, 0, 0, 0, 0, 0, prevAtt, 3'd2));
    applyStimulus(mk("open first", 0, 0, 0, 0, 0, 0, 0, 1, 0, 2'd0, 3'd3));
  endtask

  task automatic reachLockout();
    enterWrong(2'd0);
    applyStimulus(mk("idle after reject 1", 0, 0, 0, 0, 0, 0, 0, 0, 0, 2'd1, 3'd0));
    enterWrong(2'd1);
    applyStimulus(mk("idle after reject 2", 0, 0, 0, 0, 0, 0, 0, 0, 0, 2'd2, 3'd0));
    enterWrong(2'd2);
    applyStimulus(mk("lockout first", 0, 0, 0, 0, 0, 0, 0, 0, 1, 2'd3, 3'd5));
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    tableV[0]  = mk("clear beats key", 1, 4'd5, 0, 1, 0, 1, 0, 0, 0, 2'd0, 3'd0);
    tableV[1]  = mk("idle quiet",      0, 0,    0, 0, 0, 0, 0, 0, 0, 2'd0, 3'd0);
    tableV[2]  = mk("enter in idle",   0, 0,    1, 0, 0, 0, 0, 0, 0, 2'd0, 3'd0);
    tableV[3]  = mk("key 1 of 6",      1, 4'd1, 0, 0, 1, 0, 0, 0, 0, 2'd0, 3'd1);
    tableV[4]  = mk("key 2 of 6",      1, 4'd1, 0, 0, 1, 0, 0, 0, 0, 2'd0, 3'd1);
    tableV[5]  = mk("key 3 of 6",      1, 4'd1, 0, 0, 1, 0, 0, 0, 0, 2'd0, 3'd1);
    tableV[6]  = mk("key 4 of 6",      1, 4'd1, 0, 0, 1, 0, 0, 0, 0, 2'd0, 3'd1);
    tableV[7]  = mk("key 5 ignored",   1, 4'd1, 0, 0, 0, 0, 0, 0, 0, 2'd0, 3'd1);
    tableV[8]  = mk("key 6 ignored",   1, 4'd1, 0, 0, 0, 0, 0, 0, 0, 2'd0, 3'd1);
    tableV[9]  = mk("enter beats key", 1, 4'd2, 1, 0, 0, 0, 0, 0, 0, 2'd0, 3'd2);
    tableV[10] = mk("check mismatch",  0, 0,    0, 0, 0, 1, 1, 0, 0, 2'd1, 3'd4);
    tableV[11] = mk("back to idle",    0, 0,    0, 0, 0, 0, 0, 0, 0, 2'd1, 3'd0);
    tableV[12] = mk("short key 1",     1, 4'd9, 0, 0, 1, 0, 0, 0, 0, 2'd1, 3'd1);
    tableV[13] = mk("short key 2",     1, 4'd9, 0, 0, 1, 0, 0, 0, 0, 2'd1, 3'd1);
    tableV[14] = mk("short enter",     0, 0,    1, 0, 0, 1, 1, 0, 0, 2'd2, 3'd4);
    tableV[15] = mk("idle after short",0, 0,    0, 0, 0, 0, 0, 0, 0, 2'd2, 3'd0);
    tableV[16] = mk("key before clear",1, 4'd3, 0, 0, 1, 0, 0, 0, 0, 2'd2, 3'd1);
    tableV[17] = mk("clear no penalty",0, 0,    0, 1, 0, 1, 0, 0, 0, 2'd2, 3'd0);
    tableV[18] = mk("idle after clear",0, 0,    0, 0, 0, 0, 0, 0, 0, 2'd2, 3'd0);

    bus.key_valid   = 1'b0;
    bus.key_value   = '0;
    bus.enter_pulse = 1'b0;
    bus.clear_pulse = 1'b0;
    bus.code_word   = CODE;
    sys_reset       = 1'b1;
    repeat (2) @(negedge clk);
    checkValue("reset state",   int'(bus.state), 0);
    checkValue("reset attempts", int'(bus.attempts), 0);
    checkValue("reset flags", int'({bus.increment_counter_pulse, bus.restart_pulse,
                                     bus.unlock, bus.error, bus.locked_out}), 0);
    sys_reset = 1'b0;

    for (int i = 0; i < 19; i++) applyStimulus(tableV[i]);

    // Correct code clears attempts on the way into OPEN; hold is exactly 50 cycles.
    enterCorrect(2'd2);
    for (int i = 0; i < 49; i++)
      applyStimulus(mk("open hold", 1, 4'd7, 0, (i == 10), 0, 0, 0, 1, 0, 2'd0, 3'd3));
    applyStimulus(mk("open exit", 0, 0, 0, 0, 0, 1, 0, 0, 0, 2'd0, 3'd0));
    applyStimulus(mk("after open", 0, 0, 0, 0, 0, 0, 0, 0, 0, 2'd0, 3'd0));

    // Three wrong codes lock out for exactly 200 cycles, ignoring all keypad strobes.
    reachLockout();
    for (int i = 0; i < 199; i++)
      applyStimulus(mk("lockout hold", 1, 4'(i), (i % 7 == 0), (i % 11 == 0),
                       0, 0, 0, 0, 1, 2'd3, 3'd5));
    applyStimulus(mk("lockout exit", 0, 0, 0, 0, 0, 0, 0, 0, 0, 2'd0, 3'd0));
    applyStimulus(mk("key after lockout", 1, 4'd1, 0, 0, 1, 0, 0, 0, 0, 2'd0, 3'd1));
    applyStimulus(mk("clear after lockout", 0, 0, 0, 1, 0, 1, 0, 0, 0, 2'd0, 3'd0));

    // Asynchronous reset in the middle of OPEN.
    enterCorrect(2'd0);
    for (int i = 0; i < 5; i++)
      applyStimulus(mk("open before reset", 0, 0, 0, 0, 0, 0, 0, 1, 0, 2'd0, 3'd3));
    #2 sys_reset = 1'b1;
    #1;
    checkValue("async reset unlock", int'(bus.unlock), 0);
    checkValue("async reset state (open)", int'(bus.state), 0);
    @(negedge clk);
    sys_reset = 1'b0;
    applyStimulus(mk("no restart after reset", 0, 0, 0, 0, 0, 0, 0, 0, 0, 2'd0, 3'd0));

    // Asynchronous reset in the middle of LOCKOUT.
    reachLockout();
    for (int i = 0; i < 10; i++)
      applyStimulus(mk("lockout before reset", 0, 0, 0, 0, 0, 0, 0, 0, 1, 2'd3, 3'd5));
    #2 sys_reset = 1'b1;
    #1;
    checkValue("async reset locked_out", int'(bus.locked_out), 0);
    checkValue("async reset attempts", int'(bus.attempts), 0);
    checkValue("async reset state (lockout)", int'(bus.state), 0);
    @(negedge clk);
    sys_reset = 1'b0;
    applyStimulus(mk("idle after lockout reset", 0, 0, 0, 0, 0, 0, 0, 0, 0, 2'd0, 3'd0));
    applyStimulus(mk("key after lockout reset", 1, 4'd4, 0, 0, 1, 0, 0, 0, 0, 2'd0, 3'd1));

    checkValue("scoreboard drained", expQ.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
